aes_block_packer: RTL and testbench
===================================

// Module: aes_block_packer
// PURPOSE
//  Upstream feeder for the AES-128 encryptor. Collects a byte stream into 128-bit plaintext
//  blocks and applies PKCS#7 padding to the final block of each message.
//  Presents each block on a valid/ready port whose blk_data drives the encryptor data_in.
//  Carries a per-message end marker (blk_last) for the downstream framing logic.
// PARAMETERS
//  PAD_EN   1   1: PKCS#7 padding; 0: zero-fill a partial last block, never add an extra block
// PORTS
//  clk        in   1    system clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    in_data/in_last valid
//  in_ready   out  1    packer accepts a byte this cycle
//  in_data    in   8    plaintext byte
//  in_last    in   1    this byte is the last of the message (sampled only on handshake)
//  blk_valid  out  1    blk_data holds a complete block
//  blk_ready  in   1    consumer takes the block this cycle
//  blk_data   out  128  block; first byte of the block in [127:120], 16th byte in [7:0]
//  blk_last   out  1    blk_data is the final block of the message
//  msg_blks   out  16   blocks emitted in current message incl. current; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, any state): state=FILL, cnt=0, shift reg=0, blk_valid=0, blk_data=0,
//   blk_last=0, msg_blks=0, in_ready=0 while rst high. Partial data is discarded.
//  Byte handshake: in_valid&in_ready. Block handshake: blk_valid&blk_ready.
//  cnt: 5 bit, 0..16 = bytes held in the current block.
//  States:
//   FILL   in_ready=1, blk_valid=0. On accept, byte goes into slot cnt; cnt++.
//          Accept with new cnt==16: if in_last&PAD_EN, set extra_pend=1, blk_last=0 -> OUT.
//           If in_last&!PAD_EN, set blk_last=1 -> OUT. Otherwise set blk_last=0 -> OUT.
//          Accept with in_last and new cnt k<16 -> PAD.
//   PAD    1 cycle, in_ready=0. Slots k..15 are filled with 8'(16-k) (PAD_EN=1) or 8'h00
//          (PAD_EN=0). Set blk_last=1 -> OUT.
//   OUT    blk_valid=1, in_ready=0. blk_data, blk_last and msg_blks hold stable until the
//          block handshake. On handshake:
//           if extra_pend: -> EXTRA.
//           elif blk_last: msg_blks=0 -> FILL, cnt=0.
//           else: -> FILL, cnt=0.
//   EXTRA  1 cycle. Block <= {16{8'h10}}, blk_last=1, extra_pend=0 -> OUT.
//  msg_blks increments by 1 on each entry to OUT.
//  Latency:
//   16th byte accepted at cycle t -> blk_valid=1 at t+1.
//   Partial last byte at t -> PAD at t+1, blk_valid at t+2.
//   Extra pad block becomes valid 2 cycles after the handshake of the preceding block.
//  No input bubble needed: blk_ready high while in OUT gives FILL on the next cycle.
//  Max input rate: 16 bytes per 17 cycles.
//  in_valid without in_ready: no state change; in_data and in_last are ignored.
//  Empty message (no bytes): not representable, because in_last needs a byte.
//  blk_ready while blk_valid=0: ignored.
// TESTING
//  1 Bytes 00..0F, in_last on 0F, PAD_EN=1 ->
//     blk 000102..0F, blk_last=0, msg_blks=1; then blk 1010..10, blk_last=1, msg_blks=2.
//  2 3 bytes AA BB CC, last on CC ->
//     one blk AABBCC0D0D..0D (13x 0D), blk_last=1, valid 2 cycles after CC accepted.
//  3 PAD_EN=0, 20 bytes 01..14 ->
//     blk 01..10 with blk_last=0; blk 11121314 followed by 12x 00 with blk_last=1.
//  4 Backpressure: blk_ready=0 for 10 cycles on a full block ->
//     blk_data stable, in_ready=0 throughout, no byte lost when the stream resumes.
//  5 rst pulse after 7 bytes ->
//     all outputs 0 immediately; next 16 bytes 20..2F form one block 2021..2F.
//  6 Back-to-back 2-byte messages 55 66 and 77 88, blk_ready tied 1 ->
//     blocks 5566 0E..0E then 7788 0E..0E, each blk_last=1, msg_blks=1 each.

Source files
------------

// File: rtl/aes_block_packer.sv
// aes_block_packer: gathers a byte stream into 128-bit blocks for the AES-128
// encryptor. The final block of each message is padded with PKCS#7 bytes, or
// zero-filled when PAD_EN=0. Blocks are offered on a valid/ready port that
// carries an end-of-message marker and a running per-message block count.
module aes_block_packer #(
  parameter bit PAD_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [127:0] blk_data,
  output logic         blk_last,
  output logic [15:0]  msg_blks
);

  typedef enum logic [1:0] {FILL, PAD, OUT, EXTRA} state_t;

  state_t         state, state_nxt;
  logic [4:0]     cnt;
  logic [4:0]     cnt_inc;
  logic [127:0]   blk;
  logic           last_q;
  logic           extra_pend;
  logic [15:0]    msg_q;
  logic [15:0]    msg_inc;
  logic [7:0]     pad_byte;
  logic [6:0]     slot_lsb;
  logic           byte_hs;
  logic           blk_hs;

  assign byte_hs  = in_valid & in_ready;
  assign blk_hs   = blk_valid & blk_ready;
  assign cnt_inc  = cnt + 5'd1;
  assign msg_inc  = (msg_q == 16'hFFFF) ? msg_q : msg_q + 16'd1;
  assign pad_byte = PAD_EN ? {3'b000, 5'd16 - cnt} : 8'h00;
  // Slot 0 sits in the most significant byte of the block.
  assign slot_lsb = {4'd15 - cnt[3:0], 3'b000};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL: begin
        if (byte_hs) begin
          if (cnt_inc == 5'd16) state_nxt = OUT;
          else if (in_last)     state_nxt = PAD;
        end
      end
      PAD:   state_nxt = OUT;
      OUT:   if (blk_hs) state_nxt = extra_pend ? EXTRA : FILL;
      EXTRA: state_nxt = OUT;
      default: state_nxt = FILL;
    endcase
  end

  // Handshake outputs decoded from state; input side is held off during reset.
  always_comb begin
    in_ready  = (state == FILL) & ~rst;
    blk_valid = (state == OUT);
  end

  // Block assembly, padding and per-message bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      blk        <= '0;
      last_q     <= 1'b0;
      extra_pend <= 1'b0;
      msg_q      <= '0;
    end else begin
      unique case (state)
        FILL: begin
          if (byte_hs) begin
            blk[slot_lsb +: 8] <= in_data;
            cnt                <= cnt_inc;
            if (cnt_inc == 5'd16) begin
              extra_pend <= in_last & PAD_EN;
              last_q     <= in_last & ~PAD_EN;
              msg_q      <= msg_inc;
            end
          end
        end
        PAD: begin
          for (int unsigned i = 0; i < 16; i++) begin
            if (5'(i) >= cnt) blk[(15 - i) * 8 +: 8] <= pad_byte;
          end
          last_q <= 1'b1;
          msg_q  <= msg_inc;
        end
        OUT: begin
          if (blk_hs) begin
            cnt <= '0;
            if (!extra_pend && last_q) msg_q <= '0;
          end
        end
        EXTRA: begin
          blk        <= {16{8'h10}};
          last_q     <= 1'b1;
          extra_pend <= 1'b0;
          msg_q      <= msg_inc;
        end
        default: ;
      endcase
    end
  end

  assign blk_data = blk;
  assign blk_last = last_q;
  assign msg_blks = msg_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Bench for aes_block_packer: one instance with PKCS#7 padding, one zero-fill.
// A byte-level model predicts the block sequence of each instance; directed
// tests add literal expectations and latency/backpressure/reset checks.
module tb_aes_block_packer;

  typedef struct packed {
    logic [127:0] data;
    logic         last;
    logic [15:0]  msg;
  } blk_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   in_valid = '0;
  logic [1:0]   in_ready;
  logic [7:0]   in_data [2];
  logic [1:0]   in_last = '0;
  logic [1:0]   blk_valid;
  logic [1:0]   blk_ready = '0;
  logic [127:0] blk_data [2];
  logic [1:0]   blk_last;
  logic [15:0]  msg_blks [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_block_packer #(.PAD_EN(1'b1)) u_pad (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
    .blk_valid(blk_valid[0]), .blk_ready(blk_ready[0]), .blk_data(blk_data[0]),
    .blk_last(blk_last[0]), .msg_blks(msg_blks[0])
  );

  aes_block_packer #(.PAD_EN(1'b0)) u_zero (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
    .blk_valid(blk_valid[1]), .blk_ready(blk_ready[1]), .blk_data(blk_data[1]),
    .blk_last(blk_last[1]), .msg_blks(msg_blks[1])
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model + compare process per instance (g=0 padded, g=1 zero-fill).
  for (genvar g = 0; g < 2; g++) begin : mon
    localparam bit PADM = (g == 0);
    logic [7:0]  mb [16];
    int unsigned mcnt = 0;
    int unsigned mmsg = 0;
    blk_t        q[$];
    blk_t        lg[$];
    int          pend = 0;
    blk_t        e;
    blk_t        a;
    logic [127:0] dt;
    logic [7:0]  b;

    task automatic push_exp(input logic [127:0] d, input logic l);
      blk_t n;
      if (mmsg < 65535) mmsg++;
      n.data = d;
      n.last = l;
      n.msg  = 16'(mmsg);
      q.push_back(n);
      if (l) mmsg = 0;
    endtask

    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        mcnt = 0;
        mmsg = 0;
      end else begin
        if (blk_valid[g]) chk($sformatf("in_ready_low_while_valid[%0d]", g), {127'd0, in_ready[g]}, '0);
        if (blk_valid[g] && blk_ready[g]) begin
          a.data = blk_data[g];
          a.last = blk_last[g];
          a.msg  = msg_blks[g];
          lg.push_back(a);
          if (q.size() == 0) begin
            chk($sformatf("unexpected_block[%0d]", g), a.data, '0);
          end else begin
            e = q.pop_front();
            chk($sformatf("blk_data[%0d]", g), a.data, e.data);
            chk($sformatf("blk_last[%0d]", g), {127'd0, a.last}, {127'd0, e.last});
            chk($sformatf("msg_blks[%0d]", g), {112'd0, a.msg}, {112'd0, e.msg});
          end
        end
        if (in_valid[g] && in_ready[g]) begin
          mb[mcnt] = in_data[g];
          mcnt++;
          if (mcnt == 16 || in_last[g]) begin
            for (int i = 0; i < 16; i++) begin
              if (i < int'(mcnt)) b = mb[i];
              else                b = PADM ? 8'(16 - mcnt) : 8'h00;
              dt[127 - 8 * i -: 8] = b;
            end
            push_exp(dt, in_last[g] && !(PADM && mcnt == 16));
            if (PADM && in_last[g] && mcnt == 16) push_exp({16{8'h10}}, 1'b1);
            mcnt = 0;
          end
        end
      end
      pend = q.size();
    end
  end

  task automatic send(input int d, input logic [7:0] v, input logic l);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid[d] = 1'b1;
    in_data[d]  = v;
    in_last[d]  = l;
    @(negedge clk);
    while (!in_ready[d] && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("send_timeout", 128'(n), '0);
  endtask

  task automatic send_end(input int d);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (((d == 0) ? mon[0].pend : mon[1].pend) != 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("drain_timeout", 128'((d == 0) ? mon[0].pend : mon[1].pend), '0);
  endtask

  function automatic int log_size(input int d);
    return (d == 0) ? mon[0].lg.size() : mon[1].lg.size();
  endfunction

  task automatic check_log(input string name, input int d, input int idx,
                           input logic [127:0] ed, input logic el, input logic [15:0] em);
    blk_t x;
    if (idx >= log_size(d)) begin
      chk({name, "_missing"}, 128'(log_size(d)), 128'(idx + 1));
    end else begin
      x = (d == 0) ? mon[0].lg[idx] : mon[1].lg[idx];
      chk({name, "_data"}, x.data, ed);
      chk({name, "_last"}, {127'd0, x.last}, {127'd0, el});
      chk({name, "_msg"},  {112'd0, x.msg}, {112'd0, em});
    end
  endtask

  int base;

  initial begin
    in_data[0] = '0;
    in_data[1] = '0;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready",  {127'd0, in_ready[d]},  '0);
      chk("rst_blk_valid", {127'd0, blk_valid[d]}, '0);
      chk("rst_blk_data",  blk_data[d], '0);
      chk("rst_blk_last",  {127'd0, blk_last[d]},  '0);
      chk("rst_msg_blks",  {112'd0, msg_blks[d]},  '0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: full 16-byte final message -> data block then extra pad block
    base = log_size(0);
    for (int i = 0; i < 16; i++) send(0, 8'(i), i == 15);
    send_end(0);
    @(negedge clk);
    chk("t1_valid_t+1", {127'd0, blk_valid[0]}, 128'd1);
    @(posedge clk); #1;
    blk_ready[0] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    blk_ready[0] = 1'b0;
    @(negedge clk);
    chk("t1_extra_h+1", {127'd0, blk_valid[0]}, '0);
    @(negedge clk);
    chk("t1_extra_h+2", {127'd0, blk_valid[0]}, 128'd1);
    @(posedge clk); #1;
    blk_ready[0] = 1'b1;
    drain(0);
    check_log("t1_b0", 0, base,     128'h000102030405060708090a0b0c0d0e0f, 1'b0, 16'd1);
    check_log("t1_b1", 0, base + 1, {16{8'h10}}, 1'b1, 16'd2);

    // 2: 3-byte message, padded with 13x 0D, valid two cycles after last byte
    @(posedge clk); #1;
    blk_ready[0] = 1'b0;
    base = log_size(0);
    send(0, 8'hAA, 1'b0);
    send(0, 8'hBB, 1'b0);
    send(0, 8'hCC, 1'b1);
    send_end(0);
    @(negedge clk);
    chk("t2_valid_t+1", {127'd0, blk_valid[0]}, '0);
    @(negedge clk);
    chk("t2_valid_t+2", {127'd0, blk_valid[0]}, 128'd1);
    @(posedge clk); #1;
    blk_ready[0] = 1'b1;
    drain(0);
    check_log("t2_b0", 0, base, 128'hAABBCC0D0D0D0D0D0D0D0D0D0D0D0D0D, 1'b1, 16'd1);

    // 6: back-to-back 2-byte messages with consumer always ready
    base = log_size(0);
    send(0, 8'h55, 1'b0);
    send(0, 8'h66, 1'b1);
    send(0, 8'h77, 1'b0);
    send(0, 8'h88, 1'b1);
    send_end(0);
    drain(0);
    check_log("t6_b0", 0, base,     {16'h5566, {14{8'h0E}}}, 1'b1, 16'd1);
    check_log("t6_b1", 0, base + 1, {16'h7788, {14{8'h0E}}}, 1'b1, 16'd1);

    // 4: backpressure for 10 cycles on a full block while bytes wait
    @(posedge clk); #1;
    blk_ready[0] = 1'b0;
    base = log_size(0);
    for (int i = 0; i < 16; i++) send(0, 8'(8'h30 + i), 1'b0);
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, 8'(8'h40 + i), i == 3);
        send_end(0);
      end
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("t4_valid_held", {127'd0, blk_valid[0]}, 128'd1);
          chk("t4_in_ready_low", {127'd0, in_ready[0]}, '0);
          chk("t4_data_stable", blk_data[0], 128'h303132333435363738393a3b3c3d3e3f);
        end
        @(posedge clk); #1;
        blk_ready[0] = 1'b1;
      end
    join
    drain(0);
    check_log("t4_b0", 0, base,     128'h303132333435363738393a3b3c3d3e3f, 1'b0, 16'd1);
    check_log("t4_b1", 0, base + 1, {32'h40414243, {12{8'h0C}}}, 1'b1, 16'd2);

    // 3: zero-fill instance, 20 bytes -> full block then zero-filled final block
    blk_ready[1] = 1'b1;
    base = log_size(1);
    for (int i = 1; i <= 20; i++) send(1, 8'(i), i == 20);
    send_end(1);
    drain(1);
    check_log("t3_b0", 1, base,     128'h0102030405060708090a0b0c0d0e0f10, 1'b0, 16'd1);
    check_log("t3_b1", 1, base + 1, {32'h11121314, 96'd0}, 1'b1, 16'd2);

    // 5: reset after 7 bytes discards them; next 16 bytes form a clean block
    for (int i = 0; i < 7; i++) send(0, 8'(8'h60 + i), 1'b0);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_in_ready",  {127'd0, in_ready[0]},  '0);
    chk("t5_blk_valid", {127'd0, blk_valid[0]}, '0);
    chk("t5_blk_data",  blk_data[0], '0);
    chk("t5_blk_last",  {127'd0, blk_last[0]},  '0);
    chk("t5_msg_blks",  {112'd0, msg_blks[0]},  '0);
    @(posedge clk); #1;
    rst = 1'b0;
    base = log_size(0);
    for (int i = 0; i < 16; i++) send(0, 8'(8'h20 + i), 1'b0);
    send_end(0);
    drain(0);
    check_log("t5_b0", 0, base, 128'h202122232425262728292a2b2c2d2e2f, 1'b0, 16'd1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
